// File: rtl/fifo_shift_reader_if.sv
// Read port of a first-word-fall-through FIFO: rd_vld/rd_data present the head word, rd_en pops it.
interface fifo_shift_reader_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_en;

  modport master (input rd_vld, input rd_data, output rd_en);
  modport slave  (output rd_vld, output rd_data, input rd_en);
endinterface

// File: rtl/fifo_shift_reader.sv
// Drains the prefetch line FIFO in step with output video timing, delaying the pixel
// stream by DELAY_LINES lines; flushes stale words at frame start and counts underruns.
module fifo_shift_reader #(
  parameter int unsigned          DATA_WIDTH  = 8,
  parameter int unsigned          DELAY_LINES = 1,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0,
  parameter int unsigned          CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_de,
  input  logic                  in_hs,
  input  logic                  in_vs,
  fifo_shift_reader_if.master   rd,
  input  logic                  clr_status,
  output logic                  out_de,
  output logic                  out_hs,
  output logic                  out_vs,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  streaming,
  output logic                  underrun,
  output logic [CNT_WIDTH-1:0]  underrun_cnt
);

  typedef enum logic [1:0] {PRIME, STREAM, FLUSH} state_t;

  localparam logic [3:0] DELAY_CNT = 4'(DELAY_LINES);

  state_t                state, state_nxt;
  logic [3:0]            line_cnt, line_cnt_nxt;
  logic                  vs_d, de_d;
  logic                  vs_rise, line_end;
  logic                  rd_en_c;
  logic                  ur_hit;
  logic [DATA_WIDTH-1:0] pix_nxt;

  // The registered input copies double as the 1-cycle delayed timing outputs.
  assign out_de   = de_d;
  assign out_vs   = vs_d;
  assign rd.rd_en = rst & rd_en_c;

  always_comb begin
    vs_rise      = in_vs & ~vs_d;
    line_end     = de_d & ~in_de;
    state_nxt    = state;
    line_cnt_nxt = line_cnt;
    rd_en_c      = 1'b0;
    ur_hit       = 1'b0;
    pix_nxt      = '0;

    case (state)
      PRIME: begin
        if (in_de) pix_nxt = FILL_VALUE;
        if ((line_cnt == DELAY_CNT) && !in_de) state_nxt = STREAM;
        else if (line_end) line_cnt_nxt = line_cnt + 4'd1;
      end
      STREAM: begin
        rd_en_c = in_de & rd.rd_vld;
        ur_hit  = in_de & ~rd.rd_vld;
        if (in_de) pix_nxt = rd.rd_vld ? rd.rd_data : FILL_VALUE;
      end
      FLUSH: begin
        rd_en_c = rd.rd_vld;
        if (in_de) pix_nxt = FILL_VALUE;
        if (!rd.rd_vld) begin
          state_nxt    = PRIME;
          line_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = PRIME;
        line_cnt_nxt = '0;
      end
    endcase

    // Frame start overrides whatever the current state decided, including a coincident line_end.
    if (vs_rise) begin
      state_nxt    = FLUSH;
      line_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= PRIME;
      line_cnt     <= '0;
      vs_d         <= 1'b0;
      de_d         <= 1'b0;
      out_hs       <= 1'b0;
      out_data     <= '0;
      streaming    <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state     <= state_nxt;
      line_cnt  <= line_cnt_nxt;
      vs_d      <= in_vs;
      de_d      <= in_de;
      out_hs    <= in_hs;
      out_data  <= pix_nxt;
      streaming <= (state_nxt == STREAM);
      if (clr_status) begin
        underrun     <= 1'b0;
        underrun_cnt <= '0;
      end else if (ur_hit) begin
        underrun <= 1'b1;
        if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_shift_reader.sv
// Bench for fifo_shift_reader: table-driven priming vectors, hand-written corner sequences,
// and randomized frames compared cycle by cycle against a frame-phase reference model.
module tb_fifo_shift_reader;
  localparam int unsigned DW = 8;
  localparam int unsigned DL = 1;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_de, in_hs, in_vs, clr_status;
  logic          out_de, out_hs, out_vs, streaming, underrun;
  logic [DW-1:0] out_data;
  logic [CW-1:0] underrun_cnt;
  logic          out_de0, out_hs0, out_vs0, streaming0, underrun0;
  logic [DW-1:0] out_data0;
  logic [CW-1:0] underrun_cnt0;

  fifo_shift_reader_if #(.DATA_WIDTH(DW)) f_if ();
  fifo_shift_reader_if #(.DATA_WIDTH(DW)) f0_if ();

  fifo_shift_reader #(.DATA_WIDTH(DW), .DELAY_LINES(DL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs), .rd(f_if),
    .clr_status(clr_status), .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs),
    .out_data(out_data), .streaming(streaming), .underrun(underrun), .underrun_cnt(underrun_cnt));

  // Second instance with no line delay, fed by a FIFO that is never empty.
  fifo_shift_reader #(.DATA_WIDTH(DW), .DELAY_LINES(0), .CNT_WIDTH(CW)) dut0 (
    .clk(clk), .rst(rst), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs), .rd(f0_if),
    .clr_status(clr_status), .out_de(out_de0), .out_hs(out_hs0), .out_vs(out_vs0),
    .out_data(out_data0), .streaming(streaming0), .underrun(underrun0), .underrun_cnt(underrun_cnt0));

  assign f0_if.rd_vld  = 1'b1;
  assign f0_if.rd_data = 8'hA5;

  logic [7:0] fq[$];
  int n_cmp = 0;
  int n_err = 0;
  bit mchk = 1'b1;
  logic s_rd_en, s0_rd_en;

  // Reference model: frame phase expressed as "reading lines" / "draining stale words" / waiting.
  bit         m_reading, m_draining;
  int         m_lines_seen;
  bit         m_prev_de, m_prev_vs;
  logic       m_de, m_hs, m_vs;
  logic [7:0] m_data;
  bit         m_ur;
  int         m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_reading = 0; m_draining = 0; m_lines_seen = 0; m_prev_de = 0; m_prev_vs = 0;
    m_de = 0; m_hs = 0; m_vs = 0; m_data = 8'h00; m_ur = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic r, de, hs, vs, clr, vld, input logic [7:0] data);
    bit frame_start, line_done;
    if (!r) begin
      model_reset();
      return;
    end
    frame_start = vs && !m_prev_vs;
    line_done   = m_prev_de && !de;
    m_data = (de && m_reading && vld) ? data : 8'h00;
    if (clr) begin
      m_ur = 0; m_cnt = 0;
    end else if (m_reading && de && !vld) begin
      m_ur = 1;
      if (m_cnt < 65535) m_cnt++;
    end
    if (frame_start) begin
      m_draining = 1; m_reading = 0; m_lines_seen = 0;
    end else if (m_draining) begin
      if (!vld) begin m_draining = 0; m_lines_seen = 0; end
    end else if (!m_reading) begin
      if (m_lines_seen == DL && !de) m_reading = 1;
      else if (line_done) m_lines_seen++;
    end
    m_prev_de = de; m_prev_vs = vs;
    m_de = de; m_hs = hs; m_vs = vs;
  endtask

  task automatic cyc(input logic r, de, hs, vs, clr, blk);
    logic vld, exp_en;
    logic [7:0] dat;
    @(negedge clk);
    rst = r; in_de = de; in_hs = hs; in_vs = vs; clr_status = clr;
    vld = (fq.size() > 0) && !blk;
    dat = (fq.size() > 0) ? fq[0] : 8'h00;
    f_if.rd_vld  = vld;
    f_if.rd_data = dat;
    #1;
    s_rd_en  = f_if.rd_en;
    s0_rd_en = f0_if.rd_en;
    exp_en = !r ? 1'b0 : m_draining ? vld : m_reading ? (de & vld) : 1'b0;
    if (mchk) chk("model_rd_en", s_rd_en, exp_en);
    @(posedge clk);
    if (s_rd_en === 1'b1 && fq.size() > 0) void'(fq.pop_front());
    model_edge(r, de, hs, vs, clr, vld, dat);
    #1;
    if (mchk) begin
      chk("model_out_de", out_de, m_de);
      chk("model_out_hs", out_hs, m_hs);
      chk("model_out_vs", out_vs, m_vs);
      chk("model_out_data", out_data, m_data);
      chk("model_streaming", streaming, m_reading);
      chk("model_underrun", underrun, m_ur);
      chk("model_underrun_cnt", underrun_cnt, m_cnt);
    end
  endtask

  typedef struct {
    logic       de;
    logic       x_en;
    logic [7:0] x_data;
    logic       x_str;
    logic       x0_en;
    logic [7:0] x0_data;
  } vec_t;

  vec_t tv[26];

  initial begin
    int ren_cnt;
    logic [7:0] exp_d;
    logic r, de, vs, blk, clr;

    for (int i = 0; i < 26; i++) begin
      tv[i].de      = (i >= 2 && i <= 9) || (i >= 14 && i <= 21);
      tv[i].x_en    = (i >= 14 && i <= 21);
      tv[i].x_data  = tv[i].x_en ? 8'(8'h10 + i - 14) : 8'h00;
      tv[i].x_str   = (i >= 11);
      tv[i].x0_en   = tv[i].de;
      tv[i].x0_data = tv[i].de ? 8'hA5 : 8'h00;
    end

    rst = 0; in_de = 0; in_hs = 0; in_vs = 0; clr_status = 0;
    f_if.rd_vld = 0; f_if.rd_data = '0;
    model_reset();

    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("reset_streaming", streaming, 1'b0);
    chk("reset_streaming0", streaming0, 1'b0);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_underrun_cnt", underrun_cnt, 16'h0000);

    for (int w = 0; w < 16; w++) fq.push_back(8'(8'h10 + w));

    // Priming: line 0 only fills, line 1 pops 0x10..0x17; DELAY_LINES=0 instance streams at once.
    ren_cnt = 0;
    for (int i = 0; i < 26; i++) begin
      cyc(1, tv[i].de, 0, 0, 0, 0);
      if (s_rd_en === 1'b1) ren_cnt++;
      chk("tbl_rd_en", s_rd_en, tv[i].x_en);
      chk("tbl_out_de", out_de, tv[i].de);
      chk("tbl_out_data", out_data, tv[i].x_data);
      chk("tbl_streaming", streaming, tv[i].x_str);
      chk("tbl0_rd_en", s0_rd_en, tv[i].x0_en);
      chk("tbl0_out_data", out_data0, tv[i].x0_data);
      chk("tbl0_streaming", streaming0, 1'b1);
    end
    chk("tbl_rd_en_count", ren_cnt, 8);

    // Underrun at pixels 3-4.
    for (int p = 0; p < 8; p++) begin
      cyc(1, 1, 0, 0, 0, (p == 3 || p == 4));
      exp_d = (p < 3) ? 8'(8'h18 + p) : (p < 5) ? 8'h00 : 8'(8'h18 + p - 2);
      chk("ur_out_data", out_data, exp_d);
    end
    chk("ur_flag", underrun, 1'b1);
    chk("ur_cnt", underrun_cnt, 16'd2);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("clr_flag", underrun, 1'b0);
    chk("clr_cnt", underrun_cnt, 16'd0);
    cyc(1, 1, 0, 0, 1, 1);
    chk("clr_wins_flag", underrun, 1'b0);
    chk("clr_wins_cnt", underrun_cnt, 16'd0);
    cyc(1, 0, 0, 0, 0, 0);

    // Frame start with 5 stale words.
    fq.delete();
    for (int w = 0; w < 5; w++) fq.push_back(8'(8'hA0 + w));
    cyc(1, 0, 0, 1, 0, 0);
    ren_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1, (k < 4), 0, 1, 0, 0);
      if (s_rd_en === 1'b1) ren_cnt++;
      chk("flush_out_data", out_data, 8'h00);
    end
    chk("flush_rd_en_count", ren_cnt, 5);
    chk("flush_fifo_empty", fq.size(), 0);
    chk("flush_streaming", streaming, 1'b0);
    cyc(1, 0, 0, 0, 0, 0);

    // Re-prime, stream a partial line, then a 1-cycle reset mid-line.
    for (int w = 0; w < 16; w++) fq.push_back(8'(8'hB0 + w));
    for (int p = 0; p < 8; p++) cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("reprime_streaming", streaming, 1'b1);
    for (int p = 0; p < 3; p++) cyc(1, 1, 1, 0, 0, 0);
    chk("pre_rst_data", out_data, 8'hB2);
    cyc(0, 1, 1, 0, 0, 0);
    chk("rst_rd_en", s_rd_en, 1'b0);
    chk("rst_out_de", out_de, 1'b0);
    chk("rst_out_hs", out_hs, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_streaming", streaming, 1'b0);
    for (int p = 0; p < 5; p++) begin
      cyc(1, 1, 1, 0, 0, 0);
      chk("post_rst_rd_en", s_rd_en, 1'b0);
    end
    cyc(1, 0, 0, 0, 0, 0);
    chk("post_rst_prime", streaming, 1'b0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("post_rst_stream", streaming, 1'b1);

    // Saturation of the underrun counter.
    mchk = 1'b0;
    for (int i = 0; i < 70000; i++) cyc(1, 1, 0, 0, 0, 1);
    mchk = 1'b1;
    chk("sat_cnt", underrun_cnt, 16'hFFFF);
    chk("sat_flag", underrun, 1'b1);
    chk("sat_data", out_data, 8'h00);
    cyc(1, 0, 0, 0, 0, 0);

    // Randomized frames, including frame starts that coincide with a line end.
    for (int f = 0; f < 14; f++) begin
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      for (int l = 0; l < int'($urandom_range(3, 6)); l++) begin
        int len, gap;
        len = $urandom_range(4, 12);
        gap = $urandom_range(2, 5);
        for (int c = 0; c < len + gap; c++) begin
          if ($urandom_range(0, 1) == 1 && fq.size() < 2040) fq.push_back(8'($urandom));
          r   = ($urandom_range(0, 199) != 0);
          de  = (c < len);
          vs  = (c == len) && ($urandom_range(0, 5) == 0);
          blk = ($urandom_range(0, 7) == 0);
          clr = ($urandom_range(0, 39) == 0);
          cyc(r, de, 1'($urandom), vs, clr, blk);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_shift_reader.md
Name: fifo_shift_reader

Overview:
- Read-side controller for the 8-bit, 2048-deep prefetch line FIFO on the HDMI board; the FIFO is first-word-fall-through, with `rd_vld` meaning valid data is on `rd_data` and `rd_en` popping it.
- Drains the FIFO in step with the output video timing, giving a DELAY_LINES-line vertical shift of the pixel stream.
- Handles priming after reset/frame start, flushes stale words at each frame start, and detects and counts underruns.

Parameters:
- DATA_WIDTH, 8: pixel/FIFO word width.
- DELAY_LINES, 1: completed in_de lines to wait before reading begins (0..15).
- FILL_VALUE, 0: pixel emitted when no FIFO data is used.
- CNT_WIDTH, 16: underrun counter width.

Ports:
- clk  in  1  system clock; the same clock as the FIFO.
- rst  in  1  synchronous reset, active-low, sampled on the rising edge of clk.
- in_de  in  1  output-timing data enable.
- in_hs  in  1  output-timing hsync, passed through.
- in_vs  in  1  output-timing vsync, active high; its rising edge marks frame start.
- rd_vld  in  1  FIFO has a valid word on rd_data.
- rd_data  in  DATA_WIDTH  FIFO head word.
- rd_en  out  1  pop the FIFO head this cycle.
- clr_status  in  1  one-cycle pulse that clears underrun and underrun_cnt.
- out_de  out  1  in_de delayed 1 cycle.
- out_hs  out  1  in_hs delayed 1 cycle.
- out_vs  out  1  in_vs delayed 1 cycle.
- out_data  out  DATA_WIDTH  registered pixel.
- streaming  out  1  high while in state STREAM.
- underrun  out  1  sticky flag: in_de seen with rd_vld low while in STREAM.
- underrun_cnt  out  CNT_WIDTH  saturating count of underrun pixels.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=PRIME, line_cnt=0, vs_d=0, de_d=0.
  - out_de/hs/vs=0, out_data=0, underrun=0, underrun_cnt=0, streaming=0.
  - rd_en=0 while rst=0.
  - Reset mid-frame discards all state; the FIFO is not popped until re-prime completes.
- Edge detection:
  - vs_rise = in_vs & ~vs_d.
  - line_end = de_d & ~in_de (de_d/vs_d are registered copies of the inputs).
- rd_en is combinational from state, in_de and rd_vld; all other outputs are registered.
- Output timing: out_de, out_hs and out_vs equal in_de, in_hs and in_vs delayed exactly 1 clk in every state. out_data is aligned with out_de and is 0 whenever in_de was 0.
- State PRIME:
  - rd_en=0; out_data=FILL_VALUE while in_de.
  - line_cnt increments on each line_end.
  - When line_cnt==DELAY_LINES and in_de=0, go to STREAM at the next edge.
  - With DELAY_LINES=0, PRIME lasts 1 cycle.
- State STREAM:
  - rd_en = in_de & rd_vld.
  - When rd_en=1: out_data <= rd_data.
  - When in_de & ~rd_vld: out_data <= FILL_VALUE, underrun <= 1, underrun_cnt++ (saturates at all-ones).
- State FLUSH:
  - rd_en = rd_vld, regardless of in_de; popped words are discarded.
  - out_data=FILL_VALUE.
  - When rd_vld=0, go to PRIME with line_cnt=0.
- vs_rise in any state:
  - go to FLUSH next cycle and clear line_cnt.
  - The vs_rise cycle itself still behaves per the current state.
- vs_rise during FLUSH: stay in FLUSH.
- Simultaneous line_end and vs_rise: vs_rise wins, line_cnt=0.
- clr_status:
  - clears underrun and underrun_cnt next cycle.
  - If an underrun occurs in the same cycle, the clear wins and the counter reads 0.
- rd_vld dropping mid-line in STREAM: per-pixel fill, no state change. Reading resumes the same cycle rd_vld returns.
- No word is popped while in_de=0 in PRIME or STREAM.

Test Plan:
- Reset, then DELAY_LINES=1 with 8-pixel lines and the FIFO preloaded with 0x10..0x1F:
  - line 0 out_data=0x00 ×8 and rd_en never high;
  - line 1 out_data=0x10..0x17, rd_en high for exactly 8 cycles, out_de lagging in_de by 1.
- STREAM with rd_vld forced low for pixels 3–4 of an 8-pixel line:
  - out_data shows FILL at pixels 3–4 and FIFO data elsewhere;
  - underrun=1, underrun_cnt=2;
  - clr_status pulse -> both read 0 one cycle later.
- vs_rise with 5 stale words in the FIFO:
  - state goes to FLUSH;
  - rd_en is high for 5 cycles, then state=PRIME and streaming=0;
  - no data reaches out_data.
- rst driven low mid-line while streaming, for 1 cycle:
  - all outputs are 0 next cycle, rd_en=0;
  - re-prime requires DELAY_LINES line_ends.
- DELAY_LINES=0:
  - streaming=1 on the second cycle after reset release;
  - the first in_de line pops FIFO data immediately.
- 70000 underrun pixels:
  - underrun_cnt saturates at 0xFFFF.
